key_voice_allocator: RTL and testbench

- Sits directly downstream of the PS/2 keyboard decoder and consumes its 32-bit key-held bitmap.
- Converts bitmap changes into a serial stream of press/release events, one per cycle, lowest key index first.
- Assigns each pressed key to one of NUM_VOICES synth voices and steals the oldest voice when none is free.
- Drives per-voice key index and gate to the tone generators.

---
 rtl/key_voice_allocator.sv | 162 ++++++++++++++++
 tb/tb_key_voice_allocator.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_voice_allocator.sv
// Key-to-voice allocator: turns key bitmap changes into press/release events,
// one per cycle, lowest key first, and maps presses onto voices with oldest-voice stealing.
module key_voice_allocator #(
   parameter int NUM_KEYS   = 32,
   parameter int NUM_VOICES = 4,
   parameter int KEY_W      = 5,
   parameter int VOICE_W    = 2
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [NUM_KEYS-1:0]         i_key,
   output logic [NUM_VOICES*KEY_W-1:0] o_voice_key,
   output logic [NUM_VOICES-1:0]       o_voice_gate,
   output logic                        o_evt_valid,
   output logic                        o_evt_press,
   output logic [KEY_W-1:0]            o_evt_key,
   output logic [VOICE_W-1:0]          o_evt_voice,
   output logic                        o_evt_steal,
   output logic                        o_evt_hit,
   output logic                        o_busy
);

   localparam logic [VOICE_W-1:0] AGE_MAX = VOICE_W'(NUM_VOICES - 1);

   logic [NUM_KEYS-1:0]   key_r;
   logic [NUM_KEYS-1:0]   seen_r;
   logic [KEY_W-1:0]      voice_key_r [NUM_VOICES];
   logic [NUM_VOICES-1:0] gate_r;
   logic [VOICE_W-1:0]    age_r       [NUM_VOICES];

   logic [NUM_KEYS-1:0]   diff;
   logic                  evt_pending;
   logic [KEY_W-1:0]      sel_key;
   logic                  is_press;
   logic                  free_found;
   logic [VOICE_W-1:0]    free_voice;
   logic                  oldest_found;
   logic [VOICE_W-1:0]    oldest_voice;
   logic [VOICE_W-1:0]    oldest_age;
   logic                  hit_found;
   logic [VOICE_W-1:0]    hit_voice;
   logic [VOICE_W-1:0]    target_voice;
   logic                  steal;

   assign diff        = key_r ^ seen_r;
   assign evt_pending = |diff;
   assign o_busy      = evt_pending;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      sel_key = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (diff[i]) sel_key = KEY_W'(i);
      end
   end

   assign is_press = key_r[sel_key];

   // Lowest-index free voice: scan downward so the last hit is the lowest index.
   always_comb begin
      free_found = 1'b0;
      free_voice = '0;
      for (int v = NUM_VOICES - 1; v >= 0; v--) begin
         if (!gate_r[v]) begin
            free_found = 1'b1;
            free_voice = VOICE_W'(v);
         end
      end
   end

   // Oldest gated voice; a tie (should never occur) resolves to the lowest index.
   always_comb begin
      oldest_found = 1'b0;
      oldest_voice = '0;
      oldest_age   = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (gate_r[v] && (!oldest_found || age_r[v] > oldest_age)) begin
            oldest_found = 1'b1;
            oldest_voice = VOICE_W'(v);
            oldest_age   = age_r[v];
         end
      end
   end

   always_comb begin
      hit_found = 1'b0;
      hit_voice = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (gate_r[v] && voice_key_r[v] == sel_key) begin
            hit_found = 1'b1;
            hit_voice = VOICE_W'(v);
         end
      end
   end

   assign steal        = !free_found;
   assign target_voice = free_found ? free_voice : oldest_voice;

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         key_r       <= '0;
         seen_r      <= '0;
         gate_r      <= '0;
         o_evt_valid <= 1'b0;
         o_evt_press <= 1'b0;
         o_evt_key   <= '0;
         o_evt_voice <= '0;
         o_evt_steal <= 1'b0;
         o_evt_hit   <= 1'b0;
         // NOTE: the voice tables are a handful of flops feeding the tone generators, so they are reset too.
         for (int v = 0; v < NUM_VOICES; v++) begin
            voice_key_r[v] <= '0;
            age_r[v]       <= '0;
         end
      end else begin
         key_r       <= i_key;
         o_evt_valid <= 1'b0;
         o_evt_press <= 1'b0;
         o_evt_key   <= '0;
         o_evt_voice <= '0;
         o_evt_steal <= 1'b0;
         o_evt_hit   <= 1'b0;

         if (evt_pending) begin
            seen_r[sel_key] <= key_r[sel_key];
            o_evt_valid     <= 1'b1;
            o_evt_press     <= is_press;
            o_evt_key       <= sel_key;

            if (is_press) begin
               o_evt_voice <= target_voice;
               o_evt_steal <= steal;
               for (int v = 0; v < NUM_VOICES; v++) begin
                  if (VOICE_W'(v) == target_voice) begin
                     voice_key_r[v] <= sel_key;
                     gate_r[v]      <= 1'b1;
                     age_r[v]       <= '0;
                  end else if (gate_r[v] && age_r[v] != AGE_MAX) begin
                     age_r[v] <= age_r[v] + 1'b1;
                  end
               end
            end else if (hit_found) begin
               // Key and age stay put so the release tail keeps its pitch.
               gate_r[hit_voice] <= 1'b0;
               o_evt_voice       <= hit_voice;
               o_evt_hit         <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      o_voice_key = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         o_voice_key[v*KEY_W +: KEY_W] = voice_key_r[v];
      end
   end

   assign o_voice_gate = gate_r;

endmodule

// File: tb/tb_key_voice_allocator.sv
// Self-checking bench for key_voice_allocator: scenario tasks push expected events
// into a scoreboard queue that a negedge monitor pops as the DUT emits pulses.
module tb_key_voice_allocator;

   typedef struct packed {
      logic       press;
      logic [4:0] key;
      logic [1:0] voice;
      logic       steal;
      logic       hit;
   } evt_t;

   logic        i_clk;
   logic        i_rst;
   logic [31:0] i_key;
   logic [19:0] o_voice_key;
   logic [3:0]  o_voice_gate;
   logic        o_evt_valid;
   logic        o_evt_press;
   logic [4:0]  o_evt_key;
   logic [1:0]  o_evt_voice;
   logic        o_evt_steal;
   logic        o_evt_hit;
   logic        o_busy;

   int   checks   = 0;
   int   failures = 0;
   evt_t exp_q[$];

   key_voice_allocator dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_key       (i_key),
      .o_voice_key (o_voice_key),
      .o_voice_gate(o_voice_gate),
      .o_evt_valid (o_evt_valid),
      .o_evt_press (o_evt_press),
      .o_evt_key   (o_evt_key),
      .o_evt_voice (o_evt_voice),
      .o_evt_steal (o_evt_steal),
      .o_evt_hit   (o_evt_hit),
      .o_busy      (o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   function automatic evt_t mk(logic press, int key, int voice, logic steal, logic hit);
      evt_t e;
      e.press = press;
      e.key   = 5'(key);
      e.voice = 2'(voice);
      e.steal = steal;
      e.hit   = hit;
      return e;
   endfunction

   // Scoreboard monitor: every pulse must match the head of the queue.
   always @(negedge i_clk) begin
      evt_t got;
      got = {o_evt_press, o_evt_key, o_evt_voice, o_evt_steal, o_evt_hit};
      if (o_evt_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event got press=%0b key=%0d voice=%0d steal=%0b hit=%0b, none expected",
                     got.press, got.key, got.voice, got.steal, got.hit);
         end else begin
            evt_t exp;
            exp = exp_q.pop_front();
            if (got !== exp) begin
               failures++;
               $display("FAIL event got press=%0b key=%0d voice=%0d steal=%0b hit=%0b expected press=%0b key=%0d voice=%0d steal=%0b hit=%0b",
                        got.press, got.key, got.voice, got.steal, got.hit,
                        exp.press, exp.key, exp.voice, exp.steal, exp.hit);
            end
         end
      end else begin
         checks++;
         if (got !== '0) begin
            failures++;
            $display("FAIL idle_fields got %h expected 0", got);
         end
      end
   end

   task automatic tick();
      @(negedge i_clk);
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_key = '0;
      tick();
      tick();
      i_rst = 1'b0;
      tick();
   endtask

   task automatic drain(string name, int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || o_busy) && n < budget) begin
         tick();
         n++;
      end
      tick();
      checks++;
      if (exp_q.size() != 0 || o_busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_drain got pending=%0d busy=%0b expected pending=0 busy=0", name, exp_q.size(), o_busy);
         exp_q.delete();
      end
   endtask

   task automatic check_gate(string name, logic [3:0] exp);
      checks++;
      if (o_voice_gate !== exp) begin
         failures++;
         $display("FAIL %s_gate got %b expected %b", name, o_voice_gate, exp);
      end
   endtask

   task automatic check_vkey(string name, int v, int exp);
      checks++;
      if (o_voice_key[v*5 +: 5] !== 5'(exp)) begin
         failures++;
         $display("FAIL %s_voice%0d_key got %0d expected %0d", name, v, o_voice_key[v*5 +: 5], exp);
      end
   endtask

   task automatic press_one(int k, int voice, logic steal);
      exp_q.push_back(mk(1'b1, k, voice, steal, 1'b0));
      i_key[k] = 1'b1;
      drain("press", 10);
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      i_key = 32'hFFFF_FFFF;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if ({o_voice_key, o_voice_gate, o_evt_valid, o_evt_press, o_evt_key, o_evt_voice,
              o_evt_steal, o_evt_hit, o_busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs cycle %0d got gate=%b keys=%h valid=%0b busy=%0b expected all 0",
                     c, o_voice_gate, o_voice_key, o_evt_valid, o_busy);
         end
      end
      // Keys 0..3 fill free voices, then each later key steals the oldest: round-robin.
      for (int k = 0; k < 32; k++) begin
         exp_q.push_back(mk(1'b1, k, k % 4, k >= 4, 1'b0));
      end
      i_rst = 1'b0;
      drain("reset_refill", 100);
      check_gate("reset_refill", 4'b1111);
      for (int v = 0; v < 4; v++) check_vkey("reset_refill", v, 28 + v);
   endtask

   task automatic test_single_press();
      do_reset();
      exp_q.push_back(mk(1'b1, 5, 0, 1'b0, 1'b0));
      i_key = 32'h1 << 5;
      tick();
      checks++;
      if (o_evt_valid !== 1'b0 || o_busy !== 1'b1) begin
         failures++;
         $display("FAIL single_latency1 got valid=%0b busy=%0b expected valid=0 busy=1", o_evt_valid, o_busy);
      end
      tick();
      checks++;
      if (o_evt_valid !== 1'b1) begin
         failures++;
         $display("FAIL single_latency2 got valid=%0b expected 1", o_evt_valid);
      end
      check_gate("single", 4'b0001);
      check_vkey("single", 0, 5);
      drain("single", 10);
   endtask

   task automatic test_simultaneous();
      int busy_cycles;
      do_reset();
      exp_q.push_back(mk(1'b1, 1, 0, 1'b0, 1'b0));
      exp_q.push_back(mk(1'b1, 3, 1, 1'b0, 1'b0));
      exp_q.push_back(mk(1'b1, 7, 2, 1'b0, 1'b0));
      i_key = (32'h1 << 7) | (32'h1 << 3) | (32'h1 << 1);
      tick();
      busy_cycles = 0;
      for (int i = 0; i < 10; i++) begin
         if (o_busy) busy_cycles++;
         tick();
      end
      checks++;
      if (busy_cycles != 3) begin
         failures++;
         $display("FAIL simul_busy_cycles got %0d expected 3", busy_cycles);
      end
      drain("simul", 10);
      check_gate("simul", 4'b0111);
   endtask

   task automatic test_steal();
      do_reset();
      for (int k = 0; k < 4; k++) press_one(k, k, 1'b0);
      press_one(4, 0, 1'b1);
      check_vkey("steal", 0, 4);
      exp_q.push_back(mk(1'b0, 0, 0, 1'b0, 1'b0));
      i_key[0] = 1'b0;
      drain("steal_release", 10);
      check_gate("steal_release", 4'b1111);
      check_vkey("steal_release", 0, 4);
   endtask

   task automatic test_free_reuse();
      do_reset();
      for (int k = 0; k < 4; k++) press_one(k, k, 1'b0);
      exp_q.push_back(mk(1'b0, 2, 2, 1'b0, 1'b1));
      i_key[2] = 1'b0;
      drain("free", 10);
      check_gate("free", 4'b1011);
      check_vkey("free", 2, 2);
      press_one(9, 2, 1'b0);
      check_gate("reuse", 4'b1111);
      check_vkey("reuse", 2, 9);
   endtask

   task automatic test_glitch();
      do_reset();
      for (int k = 0; k < 3; k++) exp_q.push_back(mk(1'b1, k, k, 1'b0, 1'b0));
      i_key = 32'h0000_0027;
      tick();
      i_key[5] = 1'b0;
      drain("glitch", 20);
      check_gate("glitch", 4'b0111);
   endtask

   task automatic test_back_to_back();
      // Release of all held keys at once: hits on their voices in ascending key order.
      do_reset();
      for (int k = 0; k < 3; k++) press_one(k + 10, k, 1'b0);
      for (int k = 0; k < 3; k++) exp_q.push_back(mk(1'b0, k + 10, k, 1'b0, 1'b1));
      i_key = '0;
      drain("b2b_release", 20);
      check_gate("b2b_release", 4'b0000);
      check_vkey("b2b_release", 1, 11);
   endtask

   initial begin
      i_rst = 1'b1;
      i_key = '0;
      test_reset();
      test_single_press();
      test_simultaneous();
      test_steal();
      test_free_reuse();
      test_glitch();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
